// File: rtl/game_of_life_pkg.sv
// Shared definitions for the Game of Life board path.
// Provides the board geometry, the loader state encoding and the helper
// that maps a row number onto its bit slice of the flattened board
// (row r occupies bits [16r+15:16r]).
package game_of_life_pkg;

    localparam int BOARD_DIM   = 16;
    localparam int BOARD_BITS  = BOARD_DIM * BOARD_DIM;
    localparam int ROW_IDX_W   = $clog2(BOARD_DIM);
    localparam int BOARD_IDX_W = $clog2(BOARD_BITS);

    typedef enum logic {
        ENTRY = 1'b0,
        OFFER = 1'b1
    } loader_state_t;

    // Lowest bit position of a row inside the flattened board.
    function automatic logic [BOARD_IDX_W-1:0] row_lsb(input logic [ROW_IDX_W-1:0] row);
        return BOARD_IDX_W'(row) * BOARD_IDX_W'(BOARD_DIM);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter and a
// registered one-cycle press pulse on each rising edge of the accepted level.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_btn    raw asynchronous button level
//   o_press  one-cycle pulse per accepted press
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;

    // Synchronize, debounce and generate the press pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= 2'b00;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            // The counter only runs while the synchronized level disagrees
            // with the accepted one; any agreement restarts the qualification.
            if (r_sync[1] != r_level) begin
                if (r_cnt == CNT_MAX) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/game_board_loader.sv
// Stages a 16x16 board entered row by row from the switches and offers the
// finished board to the Game of Life machine over a valid/ready handshake.
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   row_bits     switch levels for the row being entered (bit c = column c)
//   btn_commit   raw commit button; writes row_bits into row row_idx
//   btn_clear    raw clear button; empties the board and restarts entry
//   load_ready   machine accepts the offered board
//   load_valid   complete board offered
//   board_o      staged board, row r at bits [16r+15:16r]
//   row_idx      next row to be written
//   xfer_done    one-cycle pulse per completed transfer
module game_board_loader
    import game_of_life_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BOARD_DIM-1:0]  row_bits,
    input  logic                  btn_commit,
    input  logic                  btn_clear,
    input  logic                  load_ready,
    output logic                  load_valid,
    output logic [BOARD_BITS-1:0] board_o,
    output logic [ROW_IDX_W-1:0]  row_idx,
    output logic                  xfer_done
);

    logic w_commit;
    logic w_clear;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_btn (
        .i_clk   (clk),
        .i_reset (reset),
        .i_btn   (btn_commit),
        .o_press (w_commit)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_btn (
        .i_clk   (clk),
        .i_reset (reset),
        .i_btn   (btn_clear),
        .o_press (w_clear)
    );

    loader_state_t         r_state;
    logic [BOARD_BITS-1:0] r_board;
    logic [ROW_IDX_W-1:0]  r_row_idx;
    logic                  r_load_valid;
    logic                  r_xfer_done;

    loader_state_t         w_state_nxt;
    logic [BOARD_BITS-1:0] w_board_nxt;
    logic [ROW_IDX_W-1:0]  w_row_nxt;
    logic                  w_valid_nxt;
    logic                  w_xfer_nxt;

    // Next-state and output decode for the entry/offer sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_board_nxt = r_board;
        w_row_nxt   = r_row_idx;
        w_valid_nxt = r_load_valid;
        w_xfer_nxt  = 1'b0;

        case (r_state)
            ENTRY: begin
                if (w_commit) begin
                    w_board_nxt[row_lsb(r_row_idx) +: BOARD_DIM] = row_bits;
                    w_row_nxt = r_row_idx + ROW_IDX_W'(1);
                    if (r_row_idx == ROW_IDX_W'(BOARD_DIM - 1)) begin
                        w_state_nxt = OFFER;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ENTRY;
                    end
                end else begin
                    w_state_nxt = ENTRY;
                end
            end
            OFFER: begin
                // Commits are dropped here; the board stays frozen until taken.
                if (r_load_valid && load_ready) begin
                    w_xfer_nxt  = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_row_nxt   = '0;
                    w_state_nxt = ENTRY;
                end else begin
                    w_state_nxt = OFFER;
                end
            end
            default: begin
                w_state_nxt = ENTRY;
                w_valid_nxt = 1'b0;
            end
        endcase

        // Clear overrides everything except a transfer completing this edge,
        // which still reports xfer_done.
        if (w_clear) begin
            w_board_nxt = '0;
            w_row_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = ENTRY;
        end else begin
            w_board_nxt = w_board_nxt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ENTRY;
            r_board      <= '0;
            r_row_idx    <= '0;
            r_load_valid <= 1'b0;
            r_xfer_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_board      <= w_board_nxt;
            r_row_idx    <= w_row_nxt;
            r_load_valid <= w_valid_nxt;
            r_xfer_done  <= w_xfer_nxt;
        end
    end

    assign load_valid = r_load_valid;
    assign board_o    = r_board;
    assign row_idx    = r_row_idx;
    assign xfer_done  = r_xfer_done;

endmodule

// File: tb/tb_game_board_loader.sv
// Self-checking bench for game_board_loader with DEBOUNCE_CYCLES=4.
// A board-level reference model (array of rows, row pointer, offered flag)
// predicts the loader state; expected transferred boards are queued and a
// monitor compares them whenever xfer_done fires.
module tb_game_board_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  row_bits = 16'h0000;
    logic         btn_commit = 1'b0;
    logic         btn_clear = 1'b0;
    logic         load_ready = 1'b0;
    logic         load_valid;
    logic [255:0] board_o;
    logic [3:0]   row_idx;
    logic         xfer_done;

    game_board_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .row_bits   (row_bits),
        .btn_commit (btn_commit),
        .btn_clear  (btn_clear),
        .load_ready (load_ready),
        .load_valid (load_valid),
        .board_o    (board_o),
        .row_idx    (row_idx),
        .xfer_done  (xfer_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_xfers = 0;
    int obs_xfers = 0;

    // Reference model
    logic [15:0]  m_rows [16];
    int           m_idx = 0;
    bit           m_valid = 1'b0;
    logic [255:0] exp_q [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_board();
        logic [255:0] b;
        b = '0;
        for (int r = 0; r < 16; r++) b[r*16 +: 16] = m_rows[r];
        return b;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 16; r++) m_rows[r] = 16'h0000;
        m_idx = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_commit(input logic [15:0] bits);
        if (!m_valid) begin
            m_rows[m_idx] = bits;
            if (m_idx == 15) begin
                m_idx = 0;
                m_valid = 1'b1;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".board"}, board_o, model_board());
        check({tag, ".row_idx"}, 256'(row_idx), 256'(m_idx));
        check({tag, ".load_valid"}, 256'(load_valid), 256'(m_valid));
    endtask

    // Clean button press: pin high for hold cycles, then low long enough
    // for the release to be accepted.
    task automatic press(input bit do_commit, input bit do_clear, input int hold);
        btn_commit = do_commit;
        btn_clear  = do_clear;
        cyc(hold);
        btn_commit = 1'b0;
        btn_clear  = 1'b0;
        cyc(12);
    endtask

    task automatic commit_row(input logic [15:0] bits);
        row_bits = bits;
        press(1'b1, 1'b0, $urandom_range(5, 9));
        model_commit(bits);
    endtask

    task automatic clear_board();
        press(1'b0, 1'b1, $urandom_range(5, 9));
        model_clear();
    endtask

    task automatic ready_pulse();
        if (m_valid) begin
            exp_q.push_back(model_board());
            exp_xfers++;
            m_idx = 0;
            m_valid = 1'b0;
        end
        load_ready = 1'b1;
        cyc(1);
        load_ready = 1'b0;
        cyc(2);
    endtask

    // Monitor: every transfer pulse must match the oldest expected board.
    always @(negedge clk) begin
        if (!reset && xfer_done) begin
            obs_xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got xfer_done=1 expected no transfer");
            end else begin
                check("xfer.board", board_o, exp_q.pop_front());
                check("xfer.load_valid", 256'(load_valid), 256'(0));
                check("xfer.row_idx", 256'(row_idx), 256'(0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        model_clear();

        // Reset and idle
        cyc(3);
        reset = 1'b0;
        cyc(20);
        check_state("reset");
        check("reset.xfer_done", 256'(xfer_done), 256'(0));

        // Held commit: one write, measured latency from pin rise
        row_bits = 16'hA5A5;
        btn_commit = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && row_idx != 4'd0) lat = n;
        end
        @(negedge clk);
        btn_commit = 1'b0;
        cyc(12);
        model_commit(16'hA5A5);
        check("latency", 256'(lat), 256'(8));
        check_state("held_commit");

        // Short glitch: no write
        row_bits = 16'h1234;
        btn_commit = 1'b1;
        cyc(3);
        btn_commit = 1'b0;
        cyc(12);
        check_state("glitch");

        // Fill 16 rows with the row index, load_ready low
        clear_board();
        for (int r = 0; r < 16; r++) begin
            commit_row(16'(r));
            check("fill.load_valid", 256'(load_valid), 256'(r == 15));
        end
        check_state("full");
        commit_row(16'hFFFF);
        commit_row(16'hBEEF);
        check_state("offer_commit_ignored");
        cyc(50);
        check("offer_hold.load_valid", 256'(load_valid), 256'(1));
        check("offer_hold.xfers", 256'(obs_xfers), 256'(0));
        ready_pulse();
        check_state("after_xfer");
        check("after_xfer.top_row", 256'(board_o[255:240]), 256'(16'h000F));
        check("after_xfer.count", 256'(obs_xfers), 256'(1));

        // Clear while offering, then clear and commit together
        for (int r = 0; r < 16; r++) commit_row(16'($urandom));
        check_state("offer2");
        clear_board();
        check_state("offer_clear");
        row_bits = 16'h5A5A;
        press(1'b1, 1'b1, 8);
        model_clear();
        check_state("clear_and_commit");

        // Reset mid-entry during a held commit
        for (int r = 0; r < 7; r++) commit_row(16'($urandom));
        check_state("pre_reset");
        row_bits = 16'hC3C3;
        btn_commit = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        model_clear();
        check_state("mid_reset");
        check("mid_reset.xfer_done", 256'(xfer_done), 256'(0));
        cyc(1);
        reset = 1'b0;
        cyc(15);
        btn_commit = 1'b0;
        cyc(12);
        model_commit(16'hC3C3);
        check_state("post_reset");

        // Randomized operation against the model
        for (int it = 0; it < 90; it++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act == 0) clear_board();
            else if (act <= 2) ready_pulse();
            else commit_row(16'($urandom));
            check_state("random");
        end
        ready_pulse();
        check_state("final");
        cyc(5);

        check("queue_empty", 256'(exp_q.size()), 256'(0));
        check("xfer_count", 256'(obs_xfers), 256'(exp_xfers));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
